// File: rtl/updn_counter_mod.sv
// Parametrised up/down modulo counter with runtime limit, synchronous load,
// wrap/saturate/one-shot boundary modes, pulse and sticky boundary flags,
// and an IDLE/RUN/HALT run-state machine. All outputs are registered.
module updn_counter_mod #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             act,
   input  logic             up_dwn_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lim,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             ovflw,
   output logic             udflw,
   output logic             ovf_sticky,
   output logic             udf_sticky,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovflw_q, ovflw_d;
   logic             udflw_q, udflw_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic             udf_sticky_q, udf_sticky_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic mode_sat;
   logic mode_one;
   logic step;
   logic boundary;

   assign mode_sat = (mode == 2'b01);
   assign mode_one = (mode == 2'b10);
   assign step     = act & ~ld & (state_q != HALT);

   // Next count, boundary pulses, sticky flags and run state.
   always_comb begin
      count_d  = count_q;
      ovflw_d  = 1'b0;
      udflw_d  = 1'b0;
      state_d  = state_q;
      boundary = 1'b0;

      if (ld) begin
         count_d = ld_val;
         state_d = IDLE;
      end else if (step) begin
         if (up_dwn_n) begin
            // count above lim (after lim shrinks or an oversized load) is
            // treated as an overflow, same as count == lim
            if (count_q >= lim) begin
               boundary = 1'b1;
               ovflw_d  = 1'b1;
               count_d  = (mode_sat || mode_one) ? lim : '0;
            end else begin
               count_d = count_q + ONE;
            end
         end else begin
            if (count_q == '0) begin
               boundary = 1'b1;
               udflw_d  = 1'b1;
               count_d  = (mode_sat || mode_one) ? '0 : lim;
            end else begin
               count_d = count_q - ONE;
            end
         end
         state_d = (boundary && mode_one) ? HALT : RUN;
      end else if (!act) begin
         state_d = IDLE;
      end

      ovf_sticky_d = ovflw_d | (ovf_sticky_q & ~clr_flags);
      udf_sticky_d = udflw_d | (udf_sticky_q & ~clr_flags);
      busy_d       = (state_d == RUN);
      done_d       = (state_d == HALT);
   end

   // Register state, count and all outputs on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         ovflw_q      <= 1'b0;
         udflw_q      <= 1'b0;
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         ovflw_q      <= ovflw_d;
         udflw_q      <= udflw_d;
         ovf_sticky_q <= ovf_sticky_d;
         udf_sticky_q <= udf_sticky_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign count      = count_q;
   assign ovflw      = ovflw_q;
   assign udflw      = udflw_q;
   assign ovf_sticky = ovf_sticky_q;
   assign udf_sticky = udf_sticky_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_updn_counter_mod.sv
// Bench for updn_counter_mod: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural model.
module tb_updn_counter_mod;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         act;
   logic         up_dwn_n;
   logic [1:0]   mode;
   logic [W-1:0] lim;
   logic         ld;
   logic [W-1:0] ld_val;
   logic         clr_flags;
   logic [W-1:0] count;
   logic         ovflw, udflw, ovf_sticky, udf_sticky, busy, done;

   int tests  = 0;
   int failed = 0;
   bit chk_en = 1'b0;

   updn_counter_mod #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .act(act), .up_dwn_n(up_dwn_n), .mode(mode),
      .lim(lim), .ld(ld), .ld_val(ld_val), .clr_flags(clr_flags),
      .count(count), .ovflw(ovflw), .udflw(udflw), .ovf_sticky(ovf_sticky),
      .udf_sticky(udf_sticky), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

   typedef struct {
      int cnt;
      int st;
      bit ov, uf, os, us;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_reset();
      mstate_t r;
      r.cnt = 0; r.st = S_IDLE; r.ov = 0; r.uf = 0; r.os = 0; r.us = 0;
      return r;
   endfunction

   function automatic mstate_t model_next(mstate_t s);
      mstate_t n;
      int      L;
      bit      hit;
      bit      clampy;
      n      = s;
      L      = int'(lim);
      hit    = 0;
      clampy = (mode == 2'd1) || (mode == 2'd2);
      n.ov   = 0;
      n.uf   = 0;
      if (ld) begin
         n.cnt = int'(ld_val);
         n.st  = S_IDLE;
      end else if (act && s.st != S_HALT) begin
         if (up_dwn_n) begin
            if (s.cnt >= L) begin hit = 1; n.ov = 1; n.cnt = clampy ? L : 0; end
            else n.cnt = s.cnt + 1;
         end else begin
            if (s.cnt == 0) begin hit = 1; n.uf = 1; n.cnt = clampy ? 0 : L; end
            else n.cnt = s.cnt - 1;
         end
         n.st = (hit && mode == 2'd2) ? S_HALT : S_RUN;
      end else if (!act) begin
         n.st = S_IDLE;
      end
      n.os = n.ov | (s.os & ~clr_flags);
      n.us = n.uf | (s.us & ~clr_flags);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m);
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m.count",  32'(count),      32'(m.cnt));
         chk("m.ovflw",  32'(ovflw),      32'(m.ov));
         chk("m.udflw",  32'(udflw),      32'(m.uf));
         chk("m.ovf_st", 32'(ovf_sticky), 32'(m.os));
         chk("m.udf_st", 32'(udf_sticky), 32'(m.us));
         chk("m.busy",   32'(busy),       32'(m.st == S_RUN));
         chk("m.done",   32'(done),       32'(m.st == S_HALT));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit a, input bit u, input logic [1:0] md,
                         input int l, input bit lo, input int lv, input bit c);
      act = a; up_dwn_n = u; mode = md; lim = W'(l); ld = lo; ld_val = W'(lv); clr_flags = c;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 1, 2'd0, 31, 0, 0, 0);
      tick(); tick();
      chk("rst_count", 32'(count), 0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_done",  32'(done),  0);
      chk("rst_flags", 32'({ovflw, udflw, ovf_sticky, udf_sticky}), 0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // wrap up through lim=31
      set_in(1, 1, 2'd0, 31, 0, 0, 0);
      for (int i = 1; i <= 33; i++) begin
         tick();
         if (i == 1)  begin chk("wrap_c1", 32'(count), 1); chk("wrap_busy", 32'(busy), 1); end
         if (i == 31) begin chk("wrap_c31", 32'(count), 31); chk("wrap_noovf", 32'(ovflw), 0); end
         if (i == 32) begin
            chk("wrap_c0",   32'(count), 0);
            chk("wrap_ovf",  32'(ovflw), 1);
            chk("wrap_osti", 32'(ovf_sticky), 1);
         end
         if (i == 33) chk("wrap_ovf_gone", 32'(ovflw), 0);
      end
      set_in(0, 1, 2'd0, 31, 0, 0, 1); tick();

      // down wrap, lim=9
      set_in(0, 0, 2'd0, 9, 1, 2, 0); tick();
      chk("dn_ld", 32'(count), 2);
      set_in(1, 0, 2'd0, 9, 0, 2, 0);
      tick(); chk("dn_c1", 32'(count), 1);
      tick(); chk("dn_c0", 32'(count), 0); chk("dn_noudf", 32'(udflw), 0);
      tick(); chk("dn_c9", 32'(count), 9); chk("dn_udf", 32'(udflw), 1);
      chk("dn_usti", 32'(udf_sticky), 1);
      set_in(0, 0, 2'd0, 9, 0, 2, 1); tick();
      chk("dn_clr", 32'(udf_sticky), 0);

      // saturate, lim=20
      set_in(0, 1, 2'd1, 20, 1, 18, 0); tick();
      set_in(1, 1, 2'd1, 20, 0, 18, 0);
      tick(); chk("sat_19", 32'(count), 19);
      tick(); chk("sat_20", 32'(count), 20); chk("sat_noovf", 32'(ovflw), 0);
      tick(); chk("sat_h1", 32'(count), 20); chk("sat_ovf1", 32'(ovflw), 1);
      tick(); chk("sat_h2", 32'(count), 20); chk("sat_ovf2", 32'(ovflw), 1);
      set_in(1, 0, 2'd1, 15, 0, 18, 0); tick();
      chk("sat_above_dn", 32'(count), 19); chk("sat_above_noudf", 32'(udflw), 0);
      set_in(0, 0, 2'd1, 15, 0, 0, 1); tick();

      // one-shot, lim=4
      set_in(0, 1, 2'd2, 4, 1, 0, 0); tick();
      set_in(1, 1, 2'd2, 4, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         tick(); chk("os_cnt", 32'(count), 32'(i));
      end
      tick();
      chk("os_cnt_hold", 32'(count), 4); chk("os_ovf", 32'(ovflw), 1);
      chk("os_done", 32'(done), 1);      chk("os_busy", 32'(busy), 0);
      tick();
      chk("os_once", 32'(ovflw), 0); chk("os_hold2", 32'(count), 4); chk("os_done2", 32'(done), 1);
      set_in(0, 1, 2'd2, 4, 0, 0, 0); tick();
      chk("os_idle", 32'(done), 0);
      set_in(1, 1, 2'd2, 4, 0, 0, 0); tick();
      chk("os_re_done", 32'(done), 1);
      set_in(1, 1, 2'd2, 4, 1, 11, 0); tick();
      chk("os_ld_done", 32'(done), 0); chk("os_ld_cnt", 32'(count), 11);
      set_in(0, 1, 2'd0, 31, 0, 0, 1); tick();

      // load beats a step; set beats clear
      set_in(1, 1, 2'd0, 31, 1, 7, 0); tick();
      chk("ldact_cnt", 32'(count), 7); chk("ldact_ovf", 32'(ovflw), 0); chk("ldact_busy", 32'(busy), 0);
      set_in(1, 1, 2'd0, 7, 0, 7, 1); tick();
      chk("setclr_cnt", 32'(count), 0); chk("setclr_sticky", 32'(ovf_sticky), 1);

      // async reset mid-count
      set_in(0, 1, 2'd0, 31, 1, 10, 0); tick();
      set_in(1, 1, 2'd0, 31, 0, 10, 0); tick(); tick(); tick();
      chk("pre_rst_cnt", 32'(count), 13);
      #2 rst_n = 1'b0;
      #1;
      chk("async_cnt",   32'(count), 0);
      chk("async_flags", 32'({ovflw, udflw, ovf_sticky, udf_sticky, busy, done}), 0);
      tick();
      rst_n = 1'b1;

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         rst_n     = ($urandom_range(0, 499) != 0);
         act       = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 7) == 0) up_dwn_n = $urandom_range(0, 1);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) lim = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
         ld        = ($urandom_range(0, 19) == 0);
         ld_val    = W'($urandom);
         clr_flags = ($urandom_range(0, 19) == 0);
         tick();
      end

      rst_n = 1'b1;
      act   = 1'b0;
      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
